// File: rtl/golden_nonce_queue.sv
// golden_nonce_queue
//
// Purpose:
//   Sits directly downstream of the miner core. Each hash2_valid strobe is
//   qualified against a leading-zero target. Every matching ("golden")
//   nonce_adjust value is queued in a small FIFO. The host side drains the
//   FIFO with a valid/ready handshake, so bursts of golden nonces survive
//   until they are read.
//
// Parameters:
//   DEPTH_LOG2  FIFO depth is 2**DEPTH_LOG2 entries (1..6)
//   ZERO_BITS   number of hash2 MSBs that must be zero for a hit (1..64)
//
// Optional feature macro:
//   GOLDEN_STATS_EN  when defined, hashes_done counts every hash2_valid strobe.
//                    When undefined, hashes_done is tied to zero and no counter
//                    logic exists.
//
// Ports:
//   clk           rising-edge clock, shared with the miner core
//   reset         synchronous, active-high; dominates everything
//   hash2_valid   core result strobe
//   hash2         core final hash (256 bits)
//   nonce_adjust  nonce that produced hash2
//   flush         new work loaded; discard every pending nonce
//   out_ready     consumer accepts the head entry
//   out_valid     FIFO is non-empty
//   out_nonce     FIFO head entry, shown whether or not out_valid is high
//   fifo_count    number of queued entries
//   overflow      sticky flag: a golden nonce was dropped because the FIFO was full
//   hashes_done   count of hash2_valid strobes (stats build only)

module golden_nonce_queue #(
  parameter int DEPTH_LOG2 = 3,
  parameter int ZERO_BITS  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hash2_valid,
  input  logic [255:0]          hash2,
  input  logic [31:0]           nonce_adjust,
  input  logic                  flush,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [31:0]           out_nonce,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow,
  output logic [31:0]           hashes_done
);

  localparam int Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FullCount = (DEPTH_LOG2 + 1)'(Depth);

  logic [31:0]           mem_q [Depth];

  logic                  hit_d, hit_q;
  logic [31:0]           nonce_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_d, rd_ptr_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_d, wr_ptr_q;
  logic [DEPTH_LOG2:0]   count_d, count_q;
  logic                  overflow_d, overflow_q;

  logic                  is_golden;
  logic                  fifo_full;
  logic                  pop;
  logic                  push_accept;
  logic                  mem_we;

  // Only the top ZERO_BITS of the hash matter. The remaining bits are
  // deliberately ignored.
  logic                  unused_hash_bits;
  assign unused_hash_bits = ^hash2[255-ZERO_BITS:0];

  assign is_golden = hash2_valid && (hash2[255 -: ZERO_BITS] == '0);
  assign fifo_full = (count_q == FullCount);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;

  // A push into a full FIFO is still accepted when a pop frees the head
  // slot in the same cycle.
  assign push_accept = hit_q & (~fifo_full | pop);
  assign mem_we      = push_accept & ~flush;

  // Next-state logic for the qualify stage and the FIFO bookkeeping.
  // flush wins over any push or pop in the same cycle. It also throws away
  // the stage-1 sample taken on the same edge.
  always_comb begin
    hit_d      = is_golden;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (flush) begin
      hit_d      = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_accept) begin
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      end
      if (push_accept && !pop) begin
        count_d = count_q + (DEPTH_LOG2 + 1)'(1);
      end else if (pop && !push_accept) begin
        count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      end
      if (hit_q && fifo_full && !pop) begin
        overflow_d = 1'b1;
      end
    end
  end

  // State registers. nonce_q is sampled on every edge. It is only consumed
  // when hit_q is set, so flush does not need to touch it.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q      <= 1'b0;
      nonce_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      hit_q      <= hit_d;
      nonce_q    <= nonce_adjust;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is cleared on reset so that out_nonce reads zero afterwards.
  // A slot is written only by an accepted push, so the head entry stays
  // stable while a handshake is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[wr_ptr_q] <= nonce_q;
    end
  end

  assign out_nonce  = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

`ifdef GOLDEN_STATS_EN
  logic [31:0] hashes_q;

  // Counts every result strobe, including non-hits. The counter wraps
  // naturally at 32 bits, and flush leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      hashes_q <= '0;
    end else if (hash2_valid) begin
      hashes_q <= hashes_q + 32'd1;
    end
  end

  assign hashes_done = hashes_q;
`else
  assign hashes_done = 32'd0;
`endif

endmodule
